// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter. A small circular FIFO absorbs bursts and
// late strobes from byte producers; a four-state machine serializes each
// byte as start bit, eight data bits LSB first, and stop bit.
module uart_tx_fifo #(
  parameter int CLK_DIV = 868,
  parameter int DEPTH   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr,
  input  logic [7:0] din,
  output logic       ready,
  output logic       txd,
  output logic       busy,
  output logic       overflow
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [15:0] DIV_M1  = 16'(CLK_DIV - 1);
  localparam logic [AW:0] RDY_MAX = (AW+1)'(DEPTH - 2);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wptr, rptr, count;
  logic        empty, full, pop, push;

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  bidx, bidx_n;
  logic [7:0]  sr, sr_n;
  logic        txd_n;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count = wptr - rptr;
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);

  // A pop on the same edge frees a slot, so a write to a full FIFO still lands.
  assign push  = wr && (!full || pop);

  // Holding ready low with one slot left gives registered producers one
  // write of slack after they sample ready.
  assign ready = (count <= RDY_MAX);
  assign busy  = !empty || (state != IDLE);

  // FIFO pointers and the sticky drop flag
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
    end else begin
      if (push)        wptr     <= wptr + PTR_ONE;
      if (pop)         rptr     <= rptr + PTR_ONE;
      if (wr && !push) overflow <= 1'b1;
    end
  end

  // FIFO storage; contents need no reset
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= din;
  end

  // TX state, bit timer, shift register and registered serial output
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      bidx  <= '0;
      sr    <= '0;
      txd   <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      bidx  <= bidx_n;
      sr    <= sr_n;
      txd   <= txd_n;
    end
  end

  // Next-state logic: each bit lasts CLK_DIV cycles; bit changes happen when
  // the timer is at zero, which also reloads it.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bidx_n  = bidx;
    sr_n    = sr;
    txd_n   = txd;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          sr_n    = mem[rptr[AW-1:0]];
          cnt_n   = DIV_M1;
          txd_n   = 1'b0;
          state_n = START;
        end else begin
          txd_n = 1'b1;
        end
      end
      START: begin
        if (cnt == '0) begin
          cnt_n   = DIV_M1;
          bidx_n  = 3'd0;
          txd_n   = sr[0];
          state_n = DATA;
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      DATA: begin
        if (cnt == '0) begin
          cnt_n = DIV_M1;
          if (bidx == 3'd7) begin
            txd_n   = 1'b1;
            state_n = STOP;
          end else begin
            bidx_n = bidx + 3'd1;
            txd_n  = sr[bidx + 3'd1];
          end
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      STOP: begin
        if (cnt == '0) begin
          cnt_n = DIV_M1;
          // Chain straight into the next start bit when more data waits.
          if (!empty) begin
            pop     = 1'b1;
            sr_n    = mem[rptr[AW-1:0]];
            txd_n   = 1'b0;
            state_n = START;
          end else begin
            txd_n   = 1'b1;
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      default: begin
        txd_n   = 1'b1;
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a queue-and-frame-timeline model predicts txd,
// busy, ready and overflow every cycle; a line receiver decodes txd back to
// bytes for in-order delivery checks.
module tb_uart_tx_fifo;
  localparam int CD    = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CD;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr = 1'b0;
  logic [7:0] din = 8'h00;
  logic       ready, txd, busy, overflow;

  uart_tx_fifo #(.CLK_DIV(CD), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .wr(wr), .din(din),
    .ready(ready), .txd(txd), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  // Model: bytes waiting, plus the frame currently on the line and its age.
  logic [7:0] m_q[$];
  logic [7:0] m_byte = 8'h00;
  bit         m_act  = 1'b0;
  int         m_t    = 0;
  bit         m_ovf  = 1'b0;
  logic [7:0] exp_rx[$];
  logic [7:0] rx[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40)
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic fbit(input logic [7:0] b, input int i);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    return f[i];
  endfunction

  // Model update at each active edge
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        m_q.delete();
        m_act = 1'b0;
        m_t   = 0;
        m_ovf = 1'b0;
        exp_rx.delete();
      end else begin
        if (!m_act) begin
          if (m_q.size() > 0) begin
            m_byte = m_q.pop_front();
            m_act  = 1'b1;
            m_t    = 0;
          end
        end else if (m_t == FRAME - 1) begin
          if (m_q.size() > 0) begin
            m_byte = m_q.pop_front();
            m_t    = 0;
          end else begin
            m_act = 1'b0;
          end
        end else begin
          m_t++;
        end
        if (wr) begin
          if (m_q.size() < DEPTH) begin
            m_q.push_back(din);
            exp_rx.push_back(din);
          end else begin
            m_ovf = 1'b1;
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("txd", txd, m_act ? fbit(m_byte, m_t / CD) : 1'b1);
      check("busy", busy, m_act || (m_q.size() != 0));
      check("ready", ready, m_q.size() <= DEPTH - 2);
      check("overflow", overflow, m_ovf);
    end
  end

  // Line receiver: mid-bit sampling from the first low sample
  logic [7:0] rx_b;
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en && !reset && txd === 1'b0) begin
        repeat (1) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
          repeat (4) @(negedge clk);
          rx_b[k] = txd;
        end
        repeat (4) @(negedge clk);
        rx.push_back(rx_b);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] b);
    wr  = 1'b1;
    din = b;
    step();
    wr  = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while (busy && n < bound) begin
      step();
      n++;
    end
    check("idle_timeout", busy, 1'b0);
    repeat (3) step();
  endtask

  task automatic rx_check(input string nm);
    check({nm, "_len"}, rx.size(), exp_rx.size());
    for (int i = 0; i < rx.size() && i < exp_rx.size(); i++)
      check({nm, "_byte"}, rx[i], exp_rx[i]);
    rx.delete();
    exp_rx.delete();
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    rx.delete();
  endtask

  int         e, s, i, n;
  bit         rp;
  logic [9:0] frame;
  string      w, msg;

  initial begin
    // Reset state
    step();
    chk_en = 1'b1;
    step();
    check("rst_txd", txd, 1'b1);
    check("rst_ready", ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    reset = 1'b0;
    step();

    // Single byte: literal frame timing
    put(8'h47);
    e = cyc;
    frame = {1'b1, 8'h47, 1'b0};
    for (int k = 1; k <= FRAME; k++) begin
      step();
      check("single_txd", txd, frame[(k - 1) / CD]);
    end
    check("single_busy_last", busy, 1'b1);
    step();
    check("single_busy_fall", busy, 1'b0);
    check("single_fall_edge", cyc, e + 41);
    repeat (3) step();
    check("single_rx_len", rx.size(), 1);
    if (rx.size() > 0) check("single_rx", rx[0], 8'h47);
    rx_check("single");

    // Back-to-back "Win\r\n" while ready
    w = "Win\r\n";
    i = 0;
    n = 0;
    while (i < w.len() && n < 200) begin
      if (ready) begin
        wr  = 1'b1;
        din = w[i];
        i++;
      end else begin
        wr = 1'b0;
      end
      step();
      n++;
    end
    wr = 1'b0;
    check("b2b_sent", i, 5);
    wait_idle(1000);
    check("b2b_rx_len", rx.size(), 5);
    if (rx.size() == 5) check("b2b_rx_last", rx[4], 8'h0A);
    rx_check("b2b");

    // Registered producer: strobe follows ready seen one cycle earlier
    msg = "Game End: 1 Win\r\n";
    i  = 0;
    n  = 0;
    rp = 1'b0;
    while ((i < msg.len() || wr) && n < 3000) begin
      wr = rp && (i < msg.len());
      if (wr) begin
        din = msg[i];
        i++;
      end
      rp = ready;
      step();
      n++;
    end
    wr = 1'b0;
    check("late_sent", i, msg.len());
    wait_idle(2000);
    check("late_ovf", overflow, 1'b0);
    check("late_rx_len", rx.size(), msg.len());
    for (int k = 0; k < rx.size() && k < msg.len(); k++)
      check("late_rx_char", rx[k], msg[k]);
    rx_check("late");

    // Write on the pop edge of a full FIFO
    put(8'h99);
    s = cyc;
    for (int k = 0; k < 4; k++) put(8'h41 + 8'(k));
    check("pp_full_ready", ready, 1'b0);
    while (cyc < s + FRAME) step();
    wr  = 1'b1;
    din = 8'h32;
    step();
    wr  = 1'b0;
    check("pp_ovf", overflow, 1'b0);
    check("pp_ready", ready, 1'b0);
    wait_idle(2000);
    check("pp_rx_len", rx.size(), 6);
    if (rx.size() == 6) check("pp_rx_last", rx[5], 8'h32);
    rx_check("pp");

    // Overflow: five writes while a frame holds the line
    put(8'hA5);
    step();
    step();
    for (int k = 0; k < 5; k++) begin
      wr  = 1'b1;
      din = 8'h11 + 8'(k);
      step();
    end
    wr = 1'b0;
    check("ovf_set", overflow, 1'b1);
    wait_idle(2000);
    check("ovf_sticky", overflow, 1'b1);
    check("ovf_rx_len", rx.size(), 5);
    rx_check("ovf");
    pulse_reset();
    check("ovf_cleared", overflow, 1'b0);

    // Random traffic ignoring ready, at several densities
    for (int k = 0; k < 1500; k++) begin
      wr  = ($urandom_range(0, 99) < ((k < 500) ? 10 : ((k < 1000) ? 40 : 3)));
      din = 8'($urandom);
      step();
    end
    wr = 1'b0;
    wait_idle(2000);
    rx_check("rand");
    pulse_reset();

    // Reset during data bit 3 of 0x55 with two bytes queued
    put(8'h55);
    e = cyc;
    put(8'h01);
    put(8'h02);
    while (cyc < e + 17) step();
    reset = 1'b1;
    step();
    check("rmf_txd", txd, 1'b1);
    check("rmf_busy", busy, 1'b0);
    check("rmf_ready", ready, 1'b1);
    check("rmf_ovf", overflow, 1'b0);
    reset = 1'b0;
    repeat (80) step();
    check("rmf_quiet_busy", busy, 1'b0);
    check("rmf_quiet_txd", txd, 1'b1);
    rx.delete();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
